ifetch_prefetch: RTL and testbench

Parametrised successor to the single-shot fetch stage. It runs a sequential PC generator that keeps up to MAX_OUT read requests in flight on an AXI read channel (AR/R only). Returned instructions go into a BUF_DEPTH prefetch buffer that drains through a valid/ready handshake to decode. A redirect from execute flushes the buffer, discards in-flight responses and restarts fetch at the new PC.

---
 rtl/ifetch_pkg.sv | 15 +
 rtl/ifetch_fifo.sv | 54 +++++
 rtl/ifetch_prefetch.sv | 145 ++++++++++++++
 tb/tb_ifetch_prefetch.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the prefetching fetch unit.
// Entry layout used by the prefetch buffer and the fetch front end.
package ifetch_pkg;

    localparam int INST_W        = 32;
    localparam int IFETCH_ADDR_W = 64;

    localparam logic [IFETCH_ADDR_W-1:0] IFETCH_RESET_PC = 64'h8000_0000;

    typedef struct packed {
        logic [IFETCH_ADDR_W-1:0] pc;
        logic [INST_W-1:0]        inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO of fetch entries.
// Flush clears in one cycle and wins over push.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         empty
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign push_ok = push && (count != CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Entry storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ifetch_prefetch.sv
// Sequential-PC prefetching fetch stage on an AXI AR/R channel.
// Define IFETCH_PERF_EN to add fetch/drop/stall performance counters.
module ifetch_prefetch
    import ifetch_pkg::*;
#(
    parameter int               ADDR_W     = 64,
    parameter int               DATA_W     = 64,
    parameter int               BUF_DEPTH  = 4,
    parameter int               MAX_OUT    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = IFETCH_RESET_PC[ADDR_W-1:0],
    parameter int               BOOT_DELAY = 10
) (
    input  logic              clk,
    input  logic              rst,
`ifdef IFETCH_PERF_EN
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_drop_cnt,
    output logic [31:0]       perf_stall_cnt,
`endif
    input  logic              redirect_vld,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_vld,
    input  logic              inst_rdy,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [63:0]       inst,
    output logic [ADDR_W-1:0] axi_AR_ADDR,
    output logic              axi_AR_VALID,
    input  logic              axi_AR_READY,
    input  logic [DATA_W-1:0] axi_R_DATA,
    input  logic              axi_R_VALID,
    output logic              axi_R_READY
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int SW = CW + 1;
    localparam int BW = $clog2(BOOT_DELAY + 2);

    logic [ADDR_W-1:0] fetch_pc, fetch_nxt;
    logic [ADDR_W-1:0] push_pc, push_nxt;
    logic [CW-1:0]     out_cnt, out_nxt;
    logic [CW-1:0]     drop_cnt, drop_nxt;
    logic [CW-1:0]     occ, occ_nxt;
    logic [BW-1:0]     boot_cnt;
    logic              ar_stale;
    logic              ar_hs, r_beat, r_drop, push, pop;
    logic              pend_nxt, raise, boot_en, empty;
    fetch_entry_t      din, head;

    assign axi_R_READY = 1'b1;
    assign ar_hs   = axi_AR_VALID && axi_AR_READY;
    assign r_beat  = axi_R_VALID && (out_cnt != '0);
    assign r_drop  = r_beat && (redirect_vld || drop_cnt != '0);
    assign push    = r_beat && !r_drop;
    assign pop     = inst_vld && inst_rdy;
    assign boot_en = (boot_cnt == BW'(BOOT_DELAY));

    assign din.pc   = IFETCH_ADDR_W'(push_pc);
    assign din.inst = push_pc[2] ? axi_R_DATA[63:32] : axi_R_DATA[31:0];

    assign inst_vld = !empty;
    assign inst_pc  = empty ? '0 : head.pc[ADDR_W-1:0];
    assign inst     = empty ? '0 : {32'b0, head.inst};

    ifetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_vld),
        .din   (din),
        .head  (head),
        .count (occ),
        .empty (empty)
    );

    // Next-state view of credits, PCs and drop count for this cycle.
    always_comb begin
        out_nxt  = out_cnt + CW'(ar_hs) - CW'(r_beat);
        occ_nxt  = redirect_vld ? '0 : occ + CW'(push) - CW'(pop);
        pend_nxt = axi_AR_VALID && !axi_AR_READY;
        fetch_nxt = fetch_pc;
        if (redirect_vld)
            fetch_nxt = redirect_pc;
        else if (ar_hs && !ar_stale)
            fetch_nxt = fetch_pc + ADDR_W'(4);
        push_nxt = push_pc;
        if (redirect_vld)
            push_nxt = redirect_pc;
        else if (push)
            push_nxt = push_pc + ADDR_W'(4);
        drop_nxt = drop_cnt;
        if (redirect_vld)
            drop_nxt = out_nxt + CW'(pend_nxt);
        else if (r_beat && drop_cnt != '0)
            drop_nxt = drop_cnt - 1'b1;
        raise = boot_en && !pend_nxt
             && ({1'b0, out_nxt} < SW'(MAX_OUT))
             && ({1'b0, occ_nxt} + {1'b0, out_nxt} < SW'(BUF_DEPTH));
    end

    // Fetch state, boot counter and registered AR request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc     <= RESET_PC;
            push_pc      <= RESET_PC;
            out_cnt      <= '0;
            drop_cnt     <= '0;
            boot_cnt     <= '0;
            ar_stale     <= 1'b0;
            axi_AR_VALID <= 1'b0;
            axi_AR_ADDR  <= '0;
        end else begin
            if (!boot_en) boot_cnt <= boot_cnt + 1'b1;
            fetch_pc <= fetch_nxt;
            push_pc  <= push_nxt;
            out_cnt  <= out_nxt;
            drop_cnt <= drop_nxt;
            ar_stale <= pend_nxt && (ar_stale || redirect_vld);
            if (pend_nxt) begin
                axi_AR_VALID <= 1'b1;
            end else if (raise) begin
                axi_AR_VALID <= 1'b1;
                axi_AR_ADDR  <= {fetch_nxt[ADDR_W-1:3], 3'b0};
            end else begin
                axi_AR_VALID <= 1'b0;
            end
        end
    end

`ifdef IFETCH_PERF_EN
    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_drop_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'(ar_hs);
            perf_drop_cnt  <= perf_drop_cnt + 32'(r_drop);
            perf_stall_cnt <= perf_stall_cnt + 32'(inst_vld && !inst_rdy);
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Randomized bench for ifetch_prefetch against an instruction-stream model.
// Memory returns a per-address word; decode must see the architectural PC stream.
module tb_ifetch_prefetch;

    localparam int MAX_OUT    = 2;
    localparam int BUF_DEPTH  = 4;
    localparam int BOOT_DELAY = 10;
    localparam logic [63:0] RPC = 64'h8000_0000;

    logic        clk, rst;
    logic        redirect_vld;
    logic [63:0] redirect_pc;
    logic        inst_vld, inst_rdy;
    logic [63:0] inst_pc, inst;
    logic [63:0] axi_AR_ADDR;
    logic        axi_AR_VALID, axi_AR_READY;
    logic [63:0] axi_R_DATA;
    logic        axi_R_VALID, axi_R_READY;

    ifetch_prefetch #(
        .ADDR_W(64), .DATA_W(64), .BUF_DEPTH(BUF_DEPTH), .MAX_OUT(MAX_OUT),
        .RESET_PC(RPC), .BOOT_DELAY(BOOT_DELAY)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
        .inst_vld(inst_vld), .inst_rdy(inst_rdy),
        .inst_pc(inst_pc), .inst(inst),
        .axi_AR_ADDR(axi_AR_ADDR), .axi_AR_VALID(axi_AR_VALID),
        .axi_AR_READY(axi_AR_READY),
        .axi_R_DATA(axi_R_DATA), .axi_R_VALID(axi_R_VALID),
        .axi_R_READY(axi_R_READY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [63:0] a; int due; } rq_t;

    rq_t         mq[$];
    logic [63:0] acc[$];
    int          n_vec, n_err, cyc, n_ar, n_pop;
    int          lat_lo, lat_hi;
    logic [63:0] exp_pc;
    bit          prev_pend;
    logic [63:0] prev_addr;
    bit          seen_ar, got_pop;
    int          first_ar_cyc;
    logic [63:0] first_ar_addr, first_pop_pc;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mw(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return lo * 32'h9E37_79B1 + 32'h1357_2468;
    endfunction

    function automatic logic [63:0] beat(input logic [63:0] a);
        logic [63:0] b;
        b = {a[63:3], 3'b000};
        return {mw(b + 64'd4), mw(b)};
    endfunction

    function automatic bit r_due();
        return mq.size() > 0 && mq[0].due <= cyc;
    endfunction

    // One clock: drive memory, model all handshakes, then advance.
    task automatic step(input bit redir = 1'b0, input logic [63:0] rpc = '0);
        bit rv;
        rv = r_due();
        axi_R_VALID  = rv;
        axi_R_DATA   = rv ? beat(mq[0].a) : '0;
        redirect_vld = redir;
        redirect_pc  = rpc;
        if (prev_pend) begin
            chk("ar_hold_vld", {63'b0, axi_AR_VALID}, 64'd1);
            chk("ar_hold_addr", axi_AR_ADDR, prev_addr);
        end
        if (axi_AR_VALID && !seen_ar) begin
            seen_ar = 1;
            first_ar_cyc = cyc;
            first_ar_addr = axi_AR_ADDR;
        end
        prev_pend = axi_AR_VALID && !axi_AR_READY;
        prev_addr = axi_AR_ADDR;
        if (rv) void'(mq.pop_front());
        if (axi_AR_VALID && axi_AR_READY) begin
            mq.push_back('{axi_AR_ADDR, cyc + $urandom_range(lat_lo, lat_hi)});
            acc.push_back(axi_AR_ADDR);
            n_ar++;
            chk("credit", 64'(mq.size() <= MAX_OUT), 64'd1);
        end
        if (inst_vld && inst_rdy) begin
            chk("pop_pc", inst_pc, exp_pc);
            chk("pop_inst", inst, {32'b0, mw(exp_pc)});
            if (!got_pop) first_pop_pc = inst_pc;
            got_pop = 1;
            exp_pc += 64'd4;
            n_pop++;
        end
        if (redir) exp_pc = rpc;
        @(posedge clk);
        #1;
        cyc++;
        redirect_vld = 1'b0;
        if (redir) chk("flush_empty", {63'b0, inst_vld}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_vld = 0; redirect_pc = 0;
        axi_R_VALID = 0; axi_R_DATA = 0;
        mq.delete(); acc.delete();
        prev_pend = 0; seen_ar = 0; got_pop = 0;
        exp_pc = RPC;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int t;
        n_vec = 0; n_err = 0; n_ar = 0; n_pop = 0;
        lat_lo = 1; lat_hi = 1;
        inst_rdy = 0; axi_AR_READY = 1;
        do_reset();
        chk("rst_ar_vld", {63'b0, axi_AR_VALID}, 64'd0);
        chk("rst_ar_addr", axi_AR_ADDR, 64'd0);
        chk("rst_r_rdy", {63'b0, axi_R_READY}, 64'd1);
        chk("rst_inst_vld", {63'b0, inst_vld}, 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);

        // Boot sequence
        inst_rdy = 1;
        n_pop = 0;
        repeat (40) step();
        chk("boot_seen", {63'b0, seen_ar}, 64'd1);
        chk("boot_no_early", 64'(first_ar_cyc >= BOOT_DELAY), 64'd1);
        chk("boot_late", 64'(first_ar_cyc <= BOOT_DELAY + 2), 64'd1);
        chk("boot_addr", first_ar_addr, RPC);
        chk("boot_pops", 64'(n_pop >= 3), 64'd1);

        // Backpressure: exactly BUF_DEPTH requests
        inst_rdy = 0;
        do_reset();
        n_ar = 0;
        repeat (40) step();
        chk("bp_ar_cnt", 64'(n_ar), 64'(BUF_DEPTH));
        chk("bp_ar_idle", {63'b0, axi_AR_VALID}, 64'd0);
        chk("bp_full", {63'b0, inst_vld}, 64'd1);
        inst_rdy = 1;
        n_pop = 0;
        repeat (12) step();
        chk("bp_drained", 64'(n_pop >= BUF_DEPTH), 64'd1);
        chk("bp_resume", 64'(n_ar > BUF_DEPTH), 64'd1);

        // Redirect with two beats outstanding
        lat_lo = 3; lat_hi = 3;
        do_reset();
        for (t = 0; t < 60 && mq.size() != 2; t++) step();
        chk("rd2_setup", 64'(mq.size()), 64'd2);
        step(1'b1, 64'h8000_1000);
        acc.delete(); got_pop = 0;
        for (t = 0; t < 60 && !got_pop; t++) step();
        chk("rd2_ar", acc.size() > 0 ? acc[0] : '1, 64'h8000_1000);
        chk("rd2_pop", got_pop ? first_pop_pc : '1, 64'h8000_1000);

        // Pending AR held across redirect
        lat_lo = 1; lat_hi = 1;
        do_reset();
        axi_AR_READY = 0;
        for (t = 0; t < 40 && !axi_AR_VALID; t++) step();
        chk("pend_setup", {63'b0, axi_AR_VALID}, 64'd1);
        step(1'b1, 64'h8000_2004);
        got_pop = 0;
        repeat (2) step();
        axi_AR_READY = 1;
        for (t = 0; t < 40 && !got_pop; t++) step();
        chk("pend_acc_cnt", 64'(acc.size() >= 2), 64'd1);
        chk("pend_old", acc.size() > 0 ? acc[0] : '1, RPC);
        chk("pend_new", acc.size() > 1 ? acc[1] : '1, 64'h8000_2000);
        chk("pend_pop", got_pop ? first_pop_pc : '1, 64'h8000_2004);

        // Beat, pop and redirect in one cycle; credits must fully return
        do_reset();
        inst_rdy = 0;
        for (t = 0; t < 60 && !(inst_vld && r_due()); t++) step();
        chk("sim_setup", 64'(inst_vld && r_due()), 64'd1);
        inst_rdy = 1;
        n_pop = 0;
        step(1'b1, 64'h8000_3000);
        chk("sim_pop", 64'(n_pop), 64'd1);
        inst_rdy = 0;
        acc.delete();
        repeat (30) step();
        chk("sim_credits", 64'(acc.size()), 64'(BUF_DEPTH));
        chk("sim_first", acc.size() > 0 ? acc[0] : '1, 64'h8000_3000);

        // Randomized traffic
        lat_lo = 1; lat_hi = 4;
        do_reset();
        n_pop = 0;
        for (int i = 0; i < 2000; i++) begin
            axi_AR_READY = ($urandom_range(0, 3) != 0);
            inst_rdy = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 39) == 0)
                step(1'b1, 64'h8000_0000 + {$urandom_range(0, 4095), 2'b00});
            else
                step();
        end
        axi_AR_READY = 1;
        chk("rand_progress", 64'(n_pop > 200), 64'd1);

        // Asynchronous reset mid-burst, then a late beat
        lat_lo = 2; lat_hi = 2;
        do_reset();
        inst_rdy = 0;
        for (t = 0; t < 60 && !(inst_vld && mq.size() > 0); t++) step();
        chk("ar_mid_setup", 64'(inst_vld && mq.size() > 0), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ar_vld", {63'b0, axi_AR_VALID}, 64'd0);
        chk("arst_ar_addr", axi_AR_ADDR, 64'd0);
        chk("arst_inst_vld", {63'b0, inst_vld}, 64'd0);
        chk("arst_inst_pc", inst_pc, 64'd0);
        chk("arst_inst", inst, 64'd0);
        chk("arst_r_rdy", {63'b0, axi_R_READY}, 64'd1);
        do_reset();
        mq.push_back('{RPC, 0});
        step();
        chk("late_beat", {63'b0, inst_vld}, 64'd0);
        repeat (3) step();
        chk("late_beat2", {63'b0, inst_vld}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
